otp_keypad_entry: RTL
=====================

Name: otp_keypad_entry

Overview:
- Input-side counterpart of the OTP display path. Captures the user's OTP one BCD digit at a time from slide switches and push keys, and assembles the 16-bit user_otp word consumed by the display multiplexer and the authenticator comparator.
- Issues a one-cycle submit strobe when a complete 4-digit code is committed.
- Runs on the slow divided display clock, so key sampling is inherently debounced.

Parameters:
- NDIG, 4, digits per OTP; fixed at 4 because user_otp is 16 bits.
- TIMEOUT_CYC, 15, idle clk_out_disp2 cycles after which a partial entry is discarded; 0 disables the timeout.
- TO_W, 4, width of the idle counter; must hold TIMEOUT_CYC.

Ports:
- clk_out_disp2  in  1  entry clock (slow divided display clock)
- rstn  in  1  asynchronous, active-low reset
- entry_en  in  1  1 = entry permitted; 0 = locked/expired, all keys ignored
- digit_sw  in  4  BCD digit presented on switches
- key_enter  in  1  level; push the digit_sw value
- key_back  in  1  level; delete the last digit
- key_clear  in  1  level; discard all digits
- key_submit  in  1  level; commit the code
- user_otp  out  16  assembled code; newest digit in [3:0]
- digit_cnt  out  3  digits held, 0..4
- otp_valid  out  1  one-cycle pulse: user_otp committed
- entry_err  out  1  one-cycle pulse: rejected key action
- timeout_evt  out  1  one-cycle pulse: partial entry discarded by timeout

Behaviour:
- Reset: async, active-low. Sets user_otp=0, digit_cnt=0, otp_valid=0, entry_err=0, timeout_evt=0, key history regs=0, idle counter=0, state=EMPTY.
- Key detection:
  - Each key is registered every cycle.
  - A press is a rising edge: current=1 and previous=0. Holding a key produces exactly one press.
  - History registers update even when entry_en=0, so a key held across enable going high does not fire.
- Priority when several presses coincide in one cycle: clear > submit > back > enter. Only the highest-priority press acts; the others are dropped silently.
- States:
  - EMPTY: digit_cnt=0.
  - PARTIAL: digit_cnt 1..3.
  - FULL: digit_cnt=4.
  - The state is derivable from digit_cnt but is held explicitly.
- enter:
  - digit_sw > 9: entry_err pulse, no change.
  - FULL: entry_err pulse, no change (no overwrite).
  - Otherwise: user_otp <= {user_otp[11:0], digit_sw}, digit_cnt+1.
- back:
  - EMPTY: entry_err pulse.
  - Otherwise: user_otp <= {4'h0, user_otp[15:4]}, digit_cnt-1.
- clear: user_otp=0, digit_cnt=0, state=EMPTY. No error in any state.
- submit:
  - FULL: otp_valid pulses for the cycle after the press. user_otp holds its value during the pulse. The next cycle clears user_otp and digit_cnt and returns to EMPTY.
  - Not FULL: entry_err pulse, no change.
- All output pulses are registered: asserted the cycle after the press is sampled, deasserted one cycle later.
- Timeout (TIMEOUT_CYC > 0):
  - The idle counter resets on any acted-on press, including one that produced entry_err. It also resets in EMPTY.
  - It increments each cycle in PARTIAL or FULL with no press.
  - On reaching TIMEOUT_CYC: clear as above, timeout_evt pulse, counter resets.
  - A press arriving in the cycle the count reaches TIMEOUT_CYC wins: the press acts and no timeout occurs.
- entry_en=0:
  - Presses are ignored, with no entry_err.
  - The idle counter holds.
  - user_otp and digit_cnt are retained.
  - A pending otp_valid clear still completes.
- Reset mid-pulse: the pulse drops immediately. Reset mid-entry: the digits are lost.
- No combinational path from any input to any output.

Test Plan:
1. Reset, entry_en=1. Enter 4,7,1,9 (one press each, separate cycles) -> user_otp=16'h4719, digit_cnt=4. Submit -> otp_valid high for one cycle with user_otp=16'h4719; next cycle user_otp=0, digit_cnt=0.
2. Enter 3, 5, then back -> user_otp=16'h0003, digit_cnt=1. back twice -> second back gives entry_err pulse, digit_cnt=0. digit_sw=4'hB + enter -> entry_err, user_otp unchanged.
3. Four digits 1,2,3,4, then enter 5 -> entry_err, user_otp stays 16'h1234. Submit with 3 digits held -> entry_err, no otp_valid.
4. Hold key_enter high 6 cycles with digit_sw=8 -> exactly one digit accepted (user_otp=16'h0008). Assert key_clear and key_enter on the same cycle -> cleared, digit_cnt=0, no digit added.
5. Enter 2 digits, then idle 15 cycles -> timeout_evt pulse on cycle 15, digit_cnt=0. Repeat with a press on cycle 15 -> press acts, no timeout_evt.
6. Enter 2 digits, drop entry_en for 30 cycles while pulsing keys -> no changes, no entry_err, no timeout. Raise entry_en; assert rstn=0 mid-entry -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/otp_keypad_entry.sv
`timescale 1ns/1ps
// OTP keypad entry: assembles a 4-digit BCD code from switch/key presses
// on the slow display clock and emits commit, error and timeout pulses.
module otp_keypad_entry #(
  parameter int NDIG        = 4,
  parameter int TIMEOUT_CYC = 15,
  parameter int TO_W        = 4
) (
  input  logic        clk_out_disp2,
  input  logic        rstn,
  input  logic        entry_en,
  input  logic [3:0]  digit_sw,
  input  logic        key_enter,
  input  logic        key_back,
  input  logic        key_clear,
  input  logic        key_submit,
  output logic [15:0] user_otp,
  output logic [2:0]  digit_cnt,
  output logic        otp_valid,
  output logic        entry_err,
  output logic        timeout_evt
);

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL, COMMIT} state_t;

  localparam logic [2:0]      LAST_DIG = 3'(NDIG - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_t          state;
  logic [3:0]      keys_p0;   // {clear, submit, back, enter} from previous cycle
  logic [3:0]      keys;
  logic [3:0]      press;
  logic            any_press;
  logic [TO_W-1:0] idle_cnt;

  always_comb begin
    keys      = {key_clear, key_submit, key_back, key_enter};
    press     = keys & ~keys_p0 & {4{entry_en}};
    any_press = |press;
  end

  always_ff @(posedge clk_out_disp2 or negedge rstn) begin
    if (!rstn) begin
      state       <= EMPTY;
      keys_p0     <= '0;
      idle_cnt    <= '0;
      user_otp    <= '0;
      digit_cnt   <= '0;
      otp_valid   <= 1'b0;
      entry_err   <= 1'b0;
      timeout_evt <= 1'b0;
    end else begin
      keys_p0     <= keys;
      otp_valid   <= 1'b0;
      entry_err   <= 1'b0;
      timeout_evt <= 1'b0;
      // The commit clear completes regardless of keys or entry_en
      if (state == COMMIT) begin
        user_otp  <= '0;
        digit_cnt <= '0;
        idle_cnt  <= '0;
        state     <= EMPTY;
      end else if (any_press) begin
        idle_cnt <= '0;
        if (press[3]) begin
          user_otp  <= '0;
          digit_cnt <= '0;
          state     <= EMPTY;
        end else if (press[2]) begin
          if (state == FULL) begin
            otp_valid <= 1'b1;
            state     <= COMMIT;
          end else begin
            entry_err <= 1'b1;
          end
        end else if (press[1]) begin
          if (state == EMPTY) begin
            entry_err <= 1'b1;
          end else begin
            user_otp  <= {4'h0, user_otp[15:4]};
            digit_cnt <= digit_cnt - 3'd1;
            state     <= (digit_cnt == 3'd1) ? EMPTY : PARTIAL;
          end
        end else begin
          if ((digit_sw > 4'd9) || (state == FULL)) begin
            entry_err <= 1'b1;
          end else begin
            user_otp  <= {user_otp[11:0], digit_sw};
            digit_cnt <= digit_cnt + 3'd1;
            state     <= (digit_cnt == LAST_DIG) ? FULL : PARTIAL;
          end
        end
      end else if (state == EMPTY) begin
        idle_cnt <= '0;
      end else if (entry_en && (TIMEOUT_CYC > 0)) begin
        if (idle_cnt == TO_LAST) begin
          user_otp    <= '0;
          digit_cnt   <= '0;
          idle_cnt    <= '0;
          state       <= EMPTY;
          timeout_evt <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

endmodule
